// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// ------------
// UART receive front-end. Synchronises the asynchronous rx line, detects a
// start-bit falling edge, and samples every subsequent bit at its centre
// using an OVERSAMPLE x baud enable. Each data bit is handed to a downstream
// right-shift (LSB-first) register as data_s plus a one-cycle shift strobe.
// At the end of the frame it pulses frame_done and reports stop-bit and
// optional parity errors.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   rx          in   raw serial line, idle high, asynchronous to clk
//   baud_tick   in   single-cycle enable at OVERSAMPLE x baud rate
//   data_s      out  sampled data bit (held between strobes)
//   shift       out  one-cycle strobe per data bit
//   busy        out  high whenever the receiver is not idle
//   frame_done  out  one-cycle pulse after the stop bit is sampled
//   frame_err   out  stop bit was sampled low (valid with frame_done)
//   parity_err  out  parity mismatch (valid with frame_done)

module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic baud_tick,
  output logic data_s,
  output logic shift,
  output logic busy,
  output logic frame_done,
  output logic frame_err,
  output logic parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Start bit is checked half a bit in; all later bits one full bit apart.
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          ACC_INIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic            r_rx_prev;
  logic [TW-1:0]   r_tick_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic            r_par_acc;
  logic            r_par_mis;
  logic            r_data_s;
  logic            r_shift;
  logic            r_busy;
  logic            r_frame_done;
  logic            r_frame_err;
  logic            r_parity_err;

  logic            w_fall;
  logic            w_half_pt;
  logic            w_full_pt;

  assign w_fall    = r_rx_prev & ~r_rx_s;
  assign w_half_pt = baud_tick & (r_tick_cnt == HALF_M1);
  assign w_full_pt = baud_tick & (r_tick_cnt == FULL_M1);

  // Two-flop synchroniser plus one more flop for falling-edge detection.
  // These run every clock regardless of baud_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_par_acc    <= 1'b0;
      r_par_mis    <= 1'b0;
      r_data_s     <= 1'b0;
      r_shift      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_shift      <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        // Edge detection is not gated by baud_tick: the edge is visible for
        // a single clock only. A line held low never produces an edge.
        S_IDLE: begin
          if (w_fall) begin
            r_tick_cnt   <= '0;
            r_par_mis    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_START;
          end
        end

        S_START: begin
          if (w_half_pt) begin
            r_tick_cnt <= '0;
            if (!r_rx_s) begin
              r_bit_cnt <= '0;
              r_par_acc <= ACC_INIT;
              r_state   <= S_DATA;
            end else begin
              // Line went high again before mid-start: treat as a glitch.
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_full_pt) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            r_data_s   <= r_rx_s;
            r_shift    <= 1'b1;
            r_par_acc  <= r_par_acc ^ r_rx_s;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_full_pt) begin
            r_tick_cnt <= '0;
            r_par_mis  <= r_par_acc ^ r_rx_s;
            r_state    <= S_STOP;
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_full_pt) begin
            r_tick_cnt   <= '0;
            r_frame_done <= 1'b1;
            r_frame_err  <= ~r_rx_s;
            r_parity_err <= (PARITY_EN != 0) ? r_par_mis : 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_s     = r_data_s;
  assign shift      = r_shift;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl. Two instances share clock, reset and
// baud_tick: u_dut0 has no parity, u_dut1 uses even parity. The serial line
// is routed to the instance selected by `sel`; the other sees an idle line.
// Expected frames are derived from the transmitted byte, parity and stop
// bit values.

module tb_uart_rx_ctrl;

  localparam int OS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic baud_tick;
  logic rx_line;
  int   sel;
  int   div;
  int   phase;
  bit   abort;

  logic rx0, rx1;
  assign rx0 = (sel == 0) ? rx_line : 1'b1;
  assign rx1 = (sel != 0) ? rx_line : 1'b1;

  logic data_s0, shift0, busy0, done0, ferr0, perr0;
  logic data_s1, shift1, busy1, done1, ferr1, perr1;

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .baud_tick(baud_tick),
    .data_s(data_s0), .shift(shift0), .busy(busy0),
    .frame_done(done0), .frame_err(ferr0), .parity_err(perr0)
  );

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .baud_tick(baud_tick),
    .data_s(data_s1), .shift(shift1), .busy(busy1),
    .frame_done(done1), .frame_err(ferr1), .parity_err(perr1)
  );

  logic m_data_s, m_shift, m_busy, m_done, m_ferr, m_perr;
  assign m_data_s = (sel != 0) ? data_s1 : data_s0;
  assign m_shift  = (sel != 0) ? shift1  : shift0;
  assign m_busy   = (sel != 0) ? busy1   : busy0;
  assign m_done   = (sel != 0) ? done1   : done0;
  assign m_ferr   = (sel != 0) ? ferr1   : ferr0;
  assign m_perr   = (sel != 0) ? perr1   : perr0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event capture on the falling edge, away from the active edge.
  int   cyc = 0;
  int   sh_cyc[$];
  logic sh_dat[$];
  logic fd_ferr[$];
  logic fd_perr[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_shift) begin
      sh_cyc.push_back(cyc);
      sh_dat.push_back(m_data_s);
    end
    if (m_done) begin
      fd_ferr.push_back(m_ferr);
      fd_perr.push_back(m_perr);
    end
  end

  task automatic clear_q();
    sh_cyc.delete();
    sh_dat.delete();
    fd_ferr.delete();
    fd_perr.delete();
  endtask

  // One clock; baud_tick asserted every `div` clocks.
  task automatic cycle();
    @(posedge clk);
    #1;
    phase     = (phase + 1 >= div) ? 0 : phase + 1;
    baud_tick = (phase == 0);
  endtask

  task automatic hold(input logic v, input int nticks);
    rx_line = abort ? 1'b1 : v;
    for (int k = 0; k < nticks * div && !abort; k++) cycle();
    if (abort) rx_line = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit pbit, input bit sbit);
    hold(1'b0, OS);
    for (int i = 0; i < 8; i++) hold(d[i], OS);
    if (has_par) hold(pbit, OS);
    hold(sbit, OS);
    hold(1'b1, 2 * OS);
  endtask

  // Reference: LSB-first bits, one strobe per data bit one bit period apart,
  // a single frame_done with the given error flags, receiver idle afterwards.
  task automatic check_frame(input string tag, input logic [7:0] d, input bit exp_ferr, input bit exp_perr);
    int n;
    logic [7:0] sr;
    n  = sh_dat.size();
    sr = 8'h00;
    check({tag, "_nshift"}, 32'(n), 32'd8);
    for (int i = 0; i < n && i < 8; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(sh_dat[i]), 32'(d[i]));
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(sh_cyc[i] - sh_cyc[i-1]), 32'(OS * div));
      sr = {sh_dat[i], sr[7:1]};
    end
    check({tag, "_shreg"}, 32'(sr), 32'(d));
    check({tag, "_ndone"}, 32'(fd_ferr.size()), 32'd1);
    if (fd_ferr.size() > 0) begin
      check({tag, "_ferr"}, 32'(fd_ferr[0]), 32'(exp_ferr));
      check({tag, "_perr"}, 32'(fd_perr[0]), 32'(exp_perr));
    end
    check({tag, "_busy"}, 32'(m_busy), 32'd0);
    clear_q();
  endtask

  initial begin
    logic [7:0] d;
    bit sbit, pbit, pgood;

    rst_n     = 1'b0;
    rx_line   = 1'b1;
    baud_tick = 1'b0;
    sel       = 0;
    div       = 1;
    phase     = 0;
    abort     = 1'b0;

    #12;
    check("rst_dut0", 32'({data_s0, shift0, busy0, done0, ferr0, perr0}), 32'd0);
    check("rst_dut1", 32'({data_s1, shift1, busy1, done1, ferr1, perr1}), 32'd0);
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (5) cycle();
    clear_q();

    // Nominal frame, tick every clock.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check_frame("nom", 8'hA5, 1'b0, 1'b0);

    // Glitch: low for 4 ticks only.
    hold(1'b0, 4);
    check("glitch_busy_hi", 32'(busy0), 32'd1);
    hold(1'b1, 30);
    check("glitch_nshift", 32'(sh_dat.size()), 32'd0);
    check("glitch_ndone", 32'(fd_ferr.size()), 32'd0);
    check("glitch_busy_lo", 32'(busy0), 32'd0);
    clear_q();

    // Framing error followed by a break.
    d = 8'h3C;
    hold(1'b0, OS);
    for (int i = 0; i < 8; i++) hold(d[i], OS);
    hold(1'b0, OS);
    hold(1'b0, 40);
    check_frame("brk", d, 1'b1, 1'b0);
    hold(1'b1, 2 * OS);
    check("brk_noretrig", 32'(fd_ferr.size() + sh_dat.size()), 32'd0);
    clear_q();

    // Even parity.
    sel = 1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check_frame("par_ok", 8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check_frame("par_bad", 8'h07, 1'b0, 1'b1);

    // Tick gating: every third clock.
    sel = 0;
    div = 3;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    check_frame("gate", 8'h81, 1'b0, 1'b0);

    // Reset after the third shift.
    div = 1;
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      begin
        for (int k = 0; k < 2000 && sh_dat.size() < 3; k++) @(negedge clk);
        check("rstmid_reach3", 32'(sh_dat.size() >= 3), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_out", 32'({data_s0, shift0, busy0, done0, ferr0, perr0}), 32'd0);
        abort = 1'b1;
      end
    join
    repeat (3) cycle();
    rst_n = 1'b1;
    abort = 1'b0;
    repeat (20 * OS) cycle();
    check("rstmid_nodone", 32'(fd_ferr.size()), 32'd0);
    clear_q();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    check_frame("post_rst", 8'h55, 1'b0, 1'b0);

    // Randomised frames on both instances.
    for (int t = 0; t < 8; t++) begin
      sel   = int'($urandom_range(0, 1));
      div   = int'($urandom_range(1, 3));
      phase = 0;
      d     = 8'($urandom);
      sbit  = ($urandom_range(0, 3) != 0);
      pgood = ($urandom_range(0, 1) != 0);
      pbit  = (^d) ^ ~pgood;
      send_frame(d, sel != 0, pbit, sbit);
      check_frame($sformatf("rnd%0d", t), d, ~sbit, (sel != 0) && (pbit != (^d)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
